// File: rtl/signal_usage_tracker.sv
// Per-signal write/read usage tracker: counts strobes in a start/stop window, then
// issues one registered report beat. Optional auto-close: SIGNAL_USAGE_TRACKER_TIMEOUT_EN.
module signal_usage_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_en,
  input  logic             wr,
  input  logic             rd,
  output logic [CNT_W-1:0] wr_nxt,
  output logic [CNT_W-1:0] rd_nxt,
  output logic             unused_nxt,
  output logic             wonly_nxt,
  output logic             ronly_nxt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] wr_cnt, rd_cnt;

  always_comb begin
    wr_nxt = wr_cnt;
    rd_nxt = rd_cnt;
    if (clr) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else if (inc_en) begin
      if (wr && wr_cnt != CNT_MAX) wr_nxt = wr_cnt + 1'b1;
      if (rd && rd_cnt != CNT_MAX) rd_nxt = rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      wr_cnt <= wr_nxt;
      rd_cnt <= rd_nxt;
    end
  end

  // Classified from the next-cycle counts so the closing cycle's events are included.
  assign unused_nxt = (wr_nxt == '0) && (rd_nxt == '0);
  assign wonly_nxt  = (wr_nxt != '0) && (rd_nxt == '0);
  assign ronly_nxt  = (wr_nxt == '0) && (rd_nxt != '0);
endmodule

module signal_usage_tracker #(
  parameter int NUM_SIG = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [NUM_SIG-1:0]       wr_evt,
  input  logic [NUM_SIG-1:0]       rd_evt,
  output logic                     busy,
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic [NUM_SIG-1:0]       rpt_unused,
  output logic [NUM_SIG-1:0]       rpt_wonly,
  output logic [NUM_SIG-1:0]       rpt_ronly,
  output logic [NUM_SIG*CNT_W-1:0] rpt_wr_cnt,
  output logic [NUM_SIG*CNT_W-1:0] rpt_rd_cnt,
  output logic                     rpt_timeout
);
  typedef enum logic [1:0] {IDLE, OBSERVE, REPORT} state_t;

  state_t state, state_nxt;
  logic   clr, load, inc_en, tmo_hit;

  logic [NUM_SIG-1:0][CNT_W-1:0] wr_nxt, rd_nxt;
  logic [NUM_SIG-1:0]            unused_nxt, wonly_nxt, ronly_nxt;
  logic [NUM_SIG-1:0][CNT_W-1:0] wr_snap, rd_snap;

  assign inc_en = (state == OBSERVE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SIG; gi++) begin : g_lane
      signal_usage_lane #(.CNT_W(CNT_W)) u_lane (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .inc_en     (inc_en),
        .wr         (wr_evt[gi]),
        .rd         (rd_evt[gi]),
        .wr_nxt     (wr_nxt[gi]),
        .rd_nxt     (rd_nxt[gi]),
        .unused_nxt (unused_nxt[gi]),
        .wonly_nxt  (wonly_nxt[gi]),
        .ronly_nxt  (ronly_nxt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = OBSERVE;
          clr       = 1'b1;
        end
      end
      OBSERVE: begin
        if (stop || tmo_hit) begin
          state_nxt = REPORT;
          load      = 1'b1;
        end
      end
      REPORT: begin
        if (rpt_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Report registers only move on window close, so they hold through IDLE and OBSERVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_unused <= '0;
      rpt_wonly  <= '0;
      rpt_ronly  <= '0;
      wr_snap    <= '0;
      rd_snap    <= '0;
    end else if (load) begin
      rpt_unused <= unused_nxt;
      rpt_wonly  <= wonly_nxt;
      rpt_ronly  <= ronly_nxt;
      wr_snap    <= wr_nxt;
      rd_snap    <= rd_nxt;
    end
  end

  assign rpt_wr_cnt = wr_snap;
  assign rpt_rd_cnt = rd_snap;
  assign rpt_valid  = (state == REPORT);
  assign busy       = (state != IDLE);

`ifdef SIGNAL_USAGE_TRACKER_TIMEOUT_EN
  logic [31:0] cyc;
  logic        tmo_q;

  // cyc counts completed OBSERVE cycles; fires on the TIMEOUT-th one.
  assign tmo_hit = (state == OBSERVE) && (cyc == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc   <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (clr)          cyc <= '0;
      else if (inc_en)  cyc <= cyc + 32'd1;
      if (clr)          tmo_q <= 1'b0;
      else if (load)    tmo_q <= !stop;
    end
  end

  assign rpt_timeout = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  // TIMEOUT is inert in this build; the compare is constant false.
  assign rpt_timeout = (TIMEOUT < 0);
`endif
endmodule
